// File: rtl/bounce_generator_if.sv
// Handshake bundle between a sequence requester and the bounce generator.
// The requester asks for one press/release sequence with start and watches
// the emulated button level together with the busy/done status.
interface bounce_if;
   logic start;
   logic button_out;
   logic busy;
   logic done;

   // Requester side: drives start, observes the generated waveform.
   modport master (
      output start,
      input  button_out,
      input  busy,
      input  done
   );

   // Generator side: samples start, produces the waveform and status.
   modport slave (
      input  start,
      output button_out,
      output busy,
      output done
   );
endinterface

// File: rtl/bounce_generator.sv
// Switch-bounce emulator. A start request produces a glitchy press burst,
// a stable high hold, a glitchy release burst and a quiet low gap, then a
// one-cycle done pulse. Glitch spacing comes from a 16-bit Fibonacci LFSR
// that steps once per output toggle, so the waveform repeats for a seed.
module bounce_generator #(
   parameter int          BOUNCES      = 2,
   parameter int          GAP_MIN      = 3,
   parameter int          GAP_BITS     = 2,
   parameter int          HOLD_CYCLES  = 20,
   parameter int          QUIET_CYCLES = 10,
   parameter logic [15:0] SEED         = 16'hACE1
) (
   input  logic     clk,
   input  logic     reset,
   bounce_if.slave  bus
);

   localparam int TIMER_W = 24;
   localparam int LAST    = 2 * BOUNCES + 1;
   localparam int CNT_W   = $clog2(2 * BOUNCES + 2);

   localparam logic [TIMER_W-1:0] HOLD_M1  = TIMER_W'(HOLD_CYCLES - 1);
   localparam logic [TIMER_W-1:0] QUIET_M1 = TIMER_W'(QUIET_CYCLES - 1);
   localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(LAST - 1);

   typedef enum logic [2:0] {
      IDLE,
      PRESS,
      HOLD,
      RELEASE,
      QUIET
   } state_t;

   state_t             state, state_next;
   logic [TIMER_W-1:0] timer, timer_next;
   logic [CNT_W-1:0]   toggle_cnt, toggle_cnt_next;
   logic [15:0]        lfsr, lfsr_next;
   logic               button_q, button_next;
   logic               done_q, done_next;

   logic [15:0]        lfsr_adv;
   logic [TIMER_W-1:0] gap_m1;
   logic               last_toggle;

   // LFSR successor, the reload value for the gap after a toggle, and
   // whether the toggle about to happen closes the current bounce phase.
   assign lfsr_adv    = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   assign gap_m1      = TIMER_W'(GAP_MIN - 1) + TIMER_W'(lfsr[GAP_BITS-1:0]);
   assign last_toggle = (toggle_cnt == CNT_LAST);

   // State register plus datapath registers; reset clears everything at once
   // so no stray toggle can follow reset release.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         timer      <= '0;
         toggle_cnt <= '0;
         lfsr       <= SEED;
         button_q   <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state      <= state_next;
         timer      <= timer_next;
         toggle_cnt <= toggle_cnt_next;
         lfsr       <= lfsr_next;
         button_q   <= button_next;
         done_q     <= done_next;
      end
   end

   // Next-state and datapath update: each phase waits for the timer to hit
   // zero, then toggles the level, steps the LFSR and reloads the timer.
   always_comb begin
      state_next      = state;
      timer_next      = timer;
      toggle_cnt_next = toggle_cnt;
      lfsr_next       = lfsr;
      button_next     = button_q;
      done_next       = 1'b0;

      case (state)
         IDLE: begin
            if (bus.start) begin
               button_next = 1'b1;
               lfsr_next   = lfsr_adv;
               if (BOUNCES == 0) begin
                  state_next      = HOLD;
                  timer_next      = HOLD_M1;
                  toggle_cnt_next = '0;
               end else begin
                  state_next      = PRESS;
                  timer_next      = gap_m1;
                  toggle_cnt_next = CNT_ONE;
               end
            end
         end

         PRESS, RELEASE: begin
            if (timer == '0) begin
               button_next     = ~button_q;
               lfsr_next       = lfsr_adv;
               toggle_cnt_next = toggle_cnt + CNT_ONE;
               if (!last_toggle) begin
                  timer_next = gap_m1;
               end else if (state == PRESS) begin
                  state_next      = HOLD;
                  timer_next      = HOLD_M1;
                  toggle_cnt_next = '0;
               end else begin
                  state_next      = QUIET;
                  timer_next      = QUIET_M1;
                  toggle_cnt_next = '0;
               end
            end else begin
               timer_next = timer - TIMER_W'(1);
            end
         end

         HOLD: begin
            if (timer == '0) begin
               button_next = 1'b0;
               lfsr_next   = lfsr_adv;
               if (BOUNCES == 0) begin
                  state_next      = QUIET;
                  timer_next      = QUIET_M1;
                  toggle_cnt_next = '0;
               end else begin
                  state_next      = RELEASE;
                  timer_next      = gap_m1;
                  toggle_cnt_next = CNT_ONE;
               end
            end else begin
               timer_next = timer - TIMER_W'(1);
            end
         end

         QUIET: begin
            if (timer == '0) begin
               done_next  = 1'b1;
               state_next = IDLE;
            end else begin
               timer_next = timer - TIMER_W'(1);
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Outputs come straight from registers so the button level is glitch-free;
   // busy is simply "not idle", which rises on start and falls with done.
   always_comb begin
      bus.button_out = button_q;
      bus.busy       = (state != IDLE);
      bus.done       = done_q;
   end

endmodule

// File: tb/tb_bounce_generator.sv
// Self-checking bench for bounce_generator. A sequence-level reference model
// turns each accepted start into the list of expected toggle levels and
// stable intervals; a monitor pops that list as the DUT toggles and checks
// spacing, levels, busy and done. A second instance exercises clean edges.
module tb_bounce_generator;

   localparam int          BOUNCES      = 2;
   localparam int          GAP_MIN      = 3;
   localparam int          GAP_BITS     = 2;
   localparam int          HOLD_CYCLES  = 20;
   localparam int          QUIET_CYCLES = 10;
   localparam logic [15:0] SEED         = 16'hACE1;
   localparam int          TOGGLES      = 2 * (2 * BOUNCES + 1);

   typedef struct {
      bit level;
      int interval;
      bit last;
   } seg_t;

   logic clk = 1'b0;
   logic reset;

   bounce_if bus ();
   bounce_if clean_bus ();

   bounce_generator #(
      .BOUNCES(BOUNCES), .GAP_MIN(GAP_MIN), .GAP_BITS(GAP_BITS),
      .HOLD_CYCLES(HOLD_CYCLES), .QUIET_CYCLES(QUIET_CYCLES), .SEED(SEED)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   bounce_generator #(
      .BOUNCES(0), .GAP_MIN(GAP_MIN), .GAP_BITS(GAP_BITS),
      .HOLD_CYCLES(HOLD_CYCLES), .QUIET_CYCLES(QUIET_CYCLES), .SEED(SEED)
   ) dut_clean (
      .clk(clk),
      .reset(reset),
      .bus(clean_bus)
   );

   seg_t        sb[$];
   int          checks        = 0;
   int          errors        = 0;
   int          cyc           = 0;
   bit          m_busy        = 1'b0;
   int          m_busy_until  = 0;
   logic [15:0] m_lfsr        = SEED;
   int          m_done_count  = 0;
   int          mon_done_count = 0;

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: actual=%0d required=%0d (cycle %0d)",
                  name, actual, expected, cyc);
      end
   endtask

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

   // Expand one accepted start into its full list of toggles: levels
   // alternate starting high, gaps come from the LFSR value seen before
   // each toggle, the last press toggle is followed by the hold and the
   // last release toggle by the quiet gap.
   task automatic push_sequence();
      seg_t s;
      int   total = 0;
      for (int i = 0; i < TOGGLES; i++) begin
         s.level = (i % 2 == 0);
         s.last  = (i == TOGGLES - 1);
         if (i == TOGGLES / 2 - 1)
            s.interval = HOLD_CYCLES;
         else if (i == TOGGLES - 1)
            s.interval = QUIET_CYCLES;
         else
            s.interval = GAP_MIN + int'(m_lfsr % (16'd1 << GAP_BITS));
         m_lfsr = lfsr_step(m_lfsr);
         total += s.interval;
         sb.push_back(s);
      end
      m_busy_until = cyc + total;
   endtask

   // Reference model: decides at each edge whether start is accepted.
   initial begin
      forever begin
         @(posedge clk or posedge reset);
         if (reset) begin
            sb.delete();
            m_busy = 1'b0;
            m_lfsr = SEED;
         end else begin
            cyc++;
            if (!m_busy) begin
               if (bus.start === 1'b1) begin
                  push_sequence();
                  m_busy = 1'b1;
               end
            end else if (cyc == m_busy_until) begin
               m_busy = 1'b0;
               m_done_count++;
            end
         end
      end
   end

   // Monitor: checks busy every cycle and each toggle/done against the queue.
   initial begin
      bit   last_btn;
      bit   have_prev;
      bit   prev_done;
      int   prev_cyc;
      seg_t cur;
      last_btn  = 1'b0;
      have_prev = 1'b0;
      prev_done = 1'b0;
      prev_cyc  = 0;
      cur       = '{level: 1'b0, interval: 0, last: 1'b0};
      forever begin
         @(negedge clk);
         if (reset !== 1'b0) begin
            last_btn  = 1'b0;
            have_prev = 1'b0;
            prev_done = 1'b0;
         end else begin
            checkOutput("busy", 32'(bus.busy), 32'(m_busy));
            if (bus.button_out !== last_btn) begin
               if (have_prev)
                  checkOutput("toggle_gap", cyc - prev_cyc, cur.interval);
               checkOutput("toggle_expected", 32'(sb.size() > 0), 1);
               if (sb.size() > 0) begin
                  cur = sb.pop_front();
                  checkOutput("toggle_level", 32'(bus.button_out), 32'(cur.level));
                  have_prev = 1'b1;
                  prev_cyc  = cyc;
               end
               last_btn = bus.button_out;
            end
            if (bus.done === 1'b1) begin
               mon_done_count++;
               checkOutput("done_after_last", 32'(have_prev && cur.last), 1);
               if (have_prev)
                  checkOutput("quiet_gap", cyc - prev_cyc, cur.interval);
               checkOutput("done_one_cycle", 32'(prev_done), 0);
               have_prev = 1'b0;
            end
            prev_done = (bus.done === 1'b1);
         end
      end
   end

   // Random start requests, one chance in one_in per cycle, busy or not.
   task automatic applyStimulus(input int n, input int one_in);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus.start = ($urandom_range(0, one_in - 1) == 0);
      end
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   // Watchdog so the run always ends.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic exp_level;
      int   drained;

      reset           = 1'b1;
      bus.start       = 1'b0;
      clean_bus.start = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_button", 32'(bus.button_out), 0);
      checkOutput("reset_busy",   32'(bus.busy), 0);
      checkOutput("reset_done",   32'(bus.done), 0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Clean edges: rise at edge 0, fall at 20, done with busy low at 30.
      $display("[TB] clean-edge instance");
      clean_bus.start = 1'b1;
      @(posedge clk);
      #1;
      clean_bus.start = 1'b0;
      checkOutput("clean_rise", 32'(clean_bus.button_out), 1);
      checkOutput("clean_busy0", 32'(clean_bus.busy), 1);
      for (int k = 1; k <= 31; k++) begin
         @(posedge clk);
         #1;
         checkOutput("clean_button", 32'(clean_bus.button_out), 32'(k < 20));
         checkOutput("clean_busy",   32'(clean_bus.busy), 32'(k < 30));
         checkOutput("clean_done",   32'(clean_bus.done), 32'(k == 30));
      end

      // Reset together with start: reset wins, nothing starts.
      $display("[TB] reset with start");
      @(negedge clk);
      reset     = 1'b1;
      bus.start = 1'b1;
      @(negedge clk);
      checkOutput("rst_start_button", 32'(bus.button_out), 0);
      checkOutput("rst_start_busy",   32'(bus.busy), 0);
      reset     = 1'b0;
      bus.start = 1'b0;
      repeat (3) @(negedge clk);

      // Reset mid-press: outputs clear without waiting for a clock edge.
      $display("[TB] reset mid-press");
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (5) @(negedge clk);
      checkOutput("midpress_busy_before", 32'(bus.busy), 1);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("async_button", 32'(bus.button_out), 0);
      checkOutput("async_busy",   32'(bus.busy), 0);
      checkOutput("async_done",   32'(bus.done), 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      repeat (100) @(negedge clk);
      checkOutput("quiet_after_reset", 32'(bus.button_out), 0);

      // Fixed bounce pattern from seed with a start pulse at edge 8.
      $display("[TB] bounce pattern with ignored start");
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      exp_level = 1'b1;
      checkOutput("pattern_edge0", 32'(bus.button_out), 32'(exp_level));
      for (int k = 1; k <= 16; k++) begin
         @(posedge clk);
         #1;
         if (k == 4 || k == 10 || k == 16)
            exp_level = ~exp_level;
         checkOutput("pattern_level", 32'(bus.button_out), 32'(exp_level));
         bus.start = (k == 7);
      end
      bus.start = 1'b0;
      repeat (150) @(negedge clk);

      $display("[TB] random starts");
      applyStimulus(2500, 12);

      $display("[TB] back-to-back starts");
      applyStimulus(300, 1);

      drained = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (!m_busy && sb.size() == 0) begin
            drained = 1;
            break;
         end
      end
      repeat (2) @(negedge clk);
      checkOutput("drain", drained, 1);
      checkOutput("done_count", mon_done_count, m_done_count);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
